int_root: RTL and testbench
===========================

# int_root

Multi-cycle integer n-th root unit for the calculator datapath, the inverse of the power block. It computes root = floor(value^(1/power)) for an 8-bit value and 4-bit exponent and returns a 4-bit root. The unit uses a bit-serial binary search, and each candidate is raised to the power by repeated multiplication with saturation. It sits beside the power unit behind the operation selector and uses a start/done handshake.

## Interface
- No parameters; widths fixed: value 8 bits, power 4 bits, root 4 bits.
- clk  input  1  rising-edge clock, single domain
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request; sampled only in IDLE
- value  input  8  radicand, latched on accepted start
- power  input  4  root degree, latched on accepted start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse
- root  output  4  floor n-th root, held until next accepted start
- exact  output  1  root^power == value
- err  output  1  power == 0 (undefined root)

## Operation
- States: IDLE, LOAD, MUL, CMP, DONE.
- IDLE: if start=1, latch value/power, clear root/exact/err, set busy, bit index i=3.
- If the latched power is 0, go to DONE with err=1, root=0, exact=0.
- Each trial uses cand = root | (1<<i).
  - LOAD: acc=1 (9-bit), cnt=power.
  - MUL: acc = acc*cand, cnt-1, repeated power times.
  - Saturation: any product >255 sets acc=256 (sticky sentinel).
  - CMP: if acc <= value, set root=cand and exact=(acc==value).
  - After CMP: i-1, then LOAD again. After i=0, go to DONE.
- Candidate 0 is never tested. If no trial is accepted, root=0 and exact=(value==0).
- power=1 with value>15 gives root=15, exact=0 (output width saturation).
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy: ignored, with no queueing.
- Inputs may change while busy; only the latched copies are used.

## Timing
- Reset (rst_n=0 at a clock edge):
  - State returns to IDLE.
  - busy=0, done=0, root=0, exact=0, err=0.
  - Reset mid-operation aborts the computation with no done pulse.
- Edge 0 is the edge that samples start=1 in IDLE. busy is visible after edge 0.
- Each trial takes power+2 edges.
- Macro absent: done is visible after edge N = 4*(power+2). It rises on the same edge that busy falls and root/exact are updated.
- power=0: done and err are visible after edge 1.
- done lasts exactly one cycle.
- The earliest next start is sampled on the edge after done. back-to-back throughput is N+1 cycles.
- root, exact and err are stable from done until the edge after the next accepted start.

## Configuration
- INT_ROOT_EARLY_EXIT_EN defined:
  - MUL ends on the edge acc saturates, and CMP follows directly.
  - Latency is variable and at most N.
  - Results are identical to the macro-absent build.
- INT_ROOT_EARLY_EXIT_EN undefined:
  - MUL always runs exactly power cycles.
  - Latency is fixed at N, data-independent.

## Test plan
- value=100, power=2 -> root=10, exact=1, err=0, done after edge 16, busy high edges 0..16.
- value=200, power=3 -> root=5, exact=0, done after edge 20. value=81, power=4 -> root=3, exact=1, done after edge 24.
- value=255, power=1 -> root=15, exact=0. value=0, power=5 -> root=0, exact=1. power=0 -> err=1, root=0, done after edge 1.
- value=255, power=8 -> root=1, exact=0, saturation exercised.
  - Macro undefined: done after edge 40.
  - Macro defined: done strictly earlier than edge 40, same root and exact.
- start pulsed at edge 5 during a power=2 job, with different operands -> ignored; the first result is unchanged, done after edge 16 only.
- rst_n=0 at edge 7 of a job -> outputs 0, busy=0, no done. A new start after release (value=16, power=2) -> root=4, exact=1.

Source files
------------

// File: rtl/int_root.sv
// ---------------------------------------------------------------------------
// int_root -- multi-cycle integer n-th root unit.
//
// Computes root = floor(value ** (1/power)) for an 8-bit radicand and a 4-bit
// degree, returning a 4-bit root.  A 4-step bit-serial binary search picks
// the root one bit at a time (MSB first).  Each candidate is raised to the
// power by repeated multiplication into a 9-bit accumulator that saturates
// at 256, so "too big" is always detectable.
//
// Optional build macro:
//   INT_ROOT_EARLY_EXIT_EN  when defined, a multiply phase stops as soon as
//                           the accumulator saturates.  Results are the same
//                           but latency becomes data dependent.  Without it
//                           latency is fixed at 4*(power+2) cycles.
//
// Handshake: start_i is sampled only while the unit is idle (IDLE, or the
// DONE cycle, which also counts as idle).  An accepted start raises busy_o
// on the next cycle.  done_o pulses for one cycle on the same edge busy_o
// falls and root_o/exact_o/err_o take their final values.  Starts seen while
// busy are dropped, never queued.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     synchronous active-low reset
//   start_i    request, sampled while idle
//   value_i    radicand (latched on accepted start)
//   power_i    root degree (latched on accepted start)
//   busy_o     high from accepted start until done
//   done_o     one-cycle completion pulse
//   root_o     floor n-th root, held until the next accepted start
//   exact_o    root_o ** power == value
//   err_o      power == 0
//   state_o    current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module int_root (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] value_i,
  input  logic [3:0] power_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] root_o,
  output logic       exact_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

`ifdef INT_ROOT_EARLY_EXIT_EN
  localparam logic EarlyExit = 1'b1;
`else
  localparam logic EarlyExit = 1'b0;
`endif

  state_t      state_q;
  logic [7:0]  value_q;
  logic [3:0]  power_q;
  logic [3:0]  work_root_q;   // root accepted so far in the search
  logic        work_exact_q;  // exactness of work_root_q
  logic [1:0]  bit_q;         // bit index under trial
  logic [8:0]  acc_q;         // candidate ** k, 256 means "saturated"
  logic [3:0]  cnt_q;         // multiplies still to do

  logic [3:0]  cand;
  logic [12:0] prod;
  logic        sat;
  logic [8:0]  acc_d;
  logic        accept;
  logic [3:0]  root_d;
  logic        exact_d;

  assign cand  = work_root_q | (4'b0001 << bit_q);
  assign prod  = {4'b0000, acc_q} * {9'b0, cand};
  // Once acc holds 256 every later product is >= 256 (cand >= 1), so the
  // sentinel is sticky without extra state.
  assign sat   = (prod > 13'd255);
  assign acc_d = sat ? 9'd256 : prod[8:0];

  // Trial outcome in CMP: keep the candidate bit if cand**power <= value.
  assign accept  = (acc_q <= {1'b0, value_q});
  assign root_d  = accept ? cand : work_root_q;
  assign exact_d = accept ? (acc_q == {1'b0, value_q}) : work_exact_q;

  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      value_q      <= 8'd0;
      power_q      <= 4'd0;
      work_root_q  <= 4'd0;
      work_exact_q <= 1'b0;
      bit_q        <= 2'd0;
      acc_q        <= 9'd0;
      cnt_q        <= 4'd0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      root_o       <= 4'd0;
      exact_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      case (state_q)
        // DONE carries the completion pulse and is otherwise idle, so a new
        // start can be taken on the very next edge.
        S_IDLE, S_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            value_q      <= value_i;
            power_q      <= power_i;
            work_root_q  <= 4'd0;
            // If no candidate is ever accepted the root is 0, exact iff 0.
            work_exact_q <= (value_i == 8'd0);
            bit_q        <= 2'd3;
            root_o       <= 4'd0;
            exact_o      <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b1;
            state_q      <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (power_q == 4'd0) begin
            err_o   <= 1'b1;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            acc_q   <= 9'd1;
            cnt_q   <= power_q;
            state_q <= S_MUL;
          end
        end

        S_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 4'd1;
          if ((cnt_q == 4'd1) || (EarlyExit && sat)) begin
            state_q <= S_CMP;
          end
        end

        S_CMP: begin
          work_root_q  <= root_d;
          work_exact_q <= exact_d;
          if (bit_q == 2'd0) begin
            root_o  <= root_d;
            exact_o <= exact_d;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            bit_q   <= bit_q - 2'd1;
            state_q <= S_LOAD;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_root.sv
// ---------------------------------------------------------------------------
// tb_int_root -- self-checking bench for int_root.
// A behavioural model derives root/exact/err from the definition
// floor(value ** (1/power)) and the job latency from the trial timing; a
// compare process checks every output against it on every cycle.  Directed
// jobs also carry hand-computed literal results and latencies.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_int_root;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] value = 8'd0;
  logic [3:0] power = 4'd0;
  logic       busy_o, done_o, exact_o, err_o;
  logic [3:0] root_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  int_root dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .value_i (value),
    .power_i (power),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .root_o  (root_o),
    .exact_o (exact_o),
    .err_o   (err_o),
    .state_o (state_o)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // r ** p, capped at 256 so "exceeds 8 bits" stays comparable.
  function automatic int pow_cap(input int r, input int p);
    int a;
    a = 1;
    for (int k = 0; k < p; k++) begin
      a = a * r;
      if (a > 255) return 256;
    end
    return a;
  endfunction

  // {err, exact, root[3:0]}
  function automatic logic [5:0] model_res(input int v, input int p);
    int r;
    logic [3:0] r4;
    if (p == 0) return 6'b10_0000;
    r = 0;
    for (int c = 1; c < 16; c++) if (pow_cap(c, p) <= v) r = c;
    r4 = r[3:0];
    return {1'b0, (pow_cap(r, p) == v), r4};
  endfunction

  function automatic int model_lat(input int v, input int p);
    if (p == 0) return 1;
`ifdef INT_ROOT_EARLY_EXIT_EN
    begin
      int r, t, c, a, k;
      r = 0;
      t = 0;
      for (int b = 3; b >= 0; b--) begin
        c = r | (1 << b);
        a = 1;
        k = 0;
        do begin
          a = a * c;
          k++;
        end while (k < p && a <= 255);
        t += 2 + k;
        if (pow_cap(c, p) <= v) r = c;
      end
      return t;
    end
`else
    return 4 * (p + 2);
`endif
  endfunction

  logic [5:0] exp_q[$];
  logic       m_busy = 1'b0, m_done = 1'b0, m_exact = 1'b0, m_err = 1'b0;
  logic [3:0] m_root = 4'd0;
  int         m_left = 0;

  always @(posedge clk) begin
    logic [5:0] r;
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_root = 4'd0; m_exact = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          r = exp_q.pop_front();
          m_err = r[5]; m_exact = r[4]; m_root = r[3:0];
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_root = 4'd0; m_exact = 1'b0; m_err = 1'b0;
        m_left = model_lat(value, power);
        exp_q.push_back(model_res(value, power));
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("root", root_o, m_root);
      chk("exact", exact_o, m_exact);
      chk("err", err_o, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_job(input int v, input int p, input int e_root, input int e_exact,
                        input int e_err, input int e_lat, input bit poke, input bit b2b);
    int e0, lat;
    bit seen;
    if (!b2b) @(negedge clk);
    start = 1'b1; value = v[7:0]; power = p[3:0];
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    value = 8'($urandom_range(0, 255));
    power = 4'($urandom_range(0, 15));
    seen = 1'b0; lat = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (poke && cyc - e0 == 4) begin
        start = 1'b1; value = 8'd9; power = 4'd2;
      end else if (poke && cyc - e0 == 5) begin
        start = 1'b0;
      end
      if (done_o) begin seen = 1'b1; lat = cyc - e0; end
    end
    chk($sformatf("done_seen v=%0d p=%0d", v, p), seen, 1);
    chk($sformatf("lit_root v=%0d p=%0d", v, p), root_o, e_root);
    chk($sformatf("lit_exact v=%0d p=%0d", v, p), exact_o, e_exact);
    chk($sformatf("lit_err v=%0d p=%0d", v, p), err_o, e_err);
`ifdef INT_ROOT_EARLY_EXIT_EN
    chk($sformatf("lat_bound v=%0d p=%0d lat=%0d", v, p, lat), int'(lat <= e_lat), 1);
    if (v == 255 && p == 8) chk("lat_early", int'(lat < e_lat), 1);
`else
    chk($sformatf("latency v=%0d p=%0d", v, p), lat, e_lat);
`endif
  endtask

  task automatic reset_mid_job();
    int e0, dones;
    @(negedge clk);
    start = 1'b1; value = 8'd100; power = 4'd2;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    while (cyc - e0 < 6) @(negedge clk);
    rst_n = 1'b0;           // sampled by edge 7
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", busy_o, 0);
    chk("rst_root", root_o, 0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    chk("rst_no_done", dones, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_root", root_o, 0);
    chk("reset_exact", exact_o, 0);
    chk("reset_err", err_o, 0);
    check_en = 1'b1;
    rst_n = 1'b1;

    do_job(100, 2, 10, 1, 0, 16, 1'b0, 1'b0);
    do_job(200, 3,  5, 0, 0, 20, 1'b0, 1'b0);
    do_job( 81, 4,  3, 1, 0, 24, 1'b0, 1'b0);
    do_job(255, 1, 15, 0, 0, 12, 1'b0, 1'b1);   // starts on the done cycle
    do_job(  0, 5,  0, 1, 0, 28, 1'b0, 1'b0);
    do_job( 37, 0,  0, 0, 1,  1, 1'b0, 1'b0);
    do_job(255, 8,  1, 0, 0, 40, 1'b0, 1'b0);
    do_job(225, 2, 15, 1, 0, 16, 1'b0, 1'b1);
    do_job(255, 2, 15, 0, 0, 16, 1'b0, 1'b0);
    do_job(128, 7,  2, 1, 0, 36, 1'b0, 1'b0);
    do_job(  1, 15, 1, 1, 0, 68, 1'b0, 1'b0);
    do_job(100, 2, 10, 1, 0, 16, 1'b1, 1'b0);   // stray start at edge 5
    reset_mid_job();
    do_job( 16, 2,  4, 1, 0, 16, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
